// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory ready handshake, illegal-opcode pulse and retired counter.
module multicycle_control_unit #(
  parameter int OPCODE_WIDTH = 4,
  parameter int ALU_OP_WIDTH = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic                    ir_write,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    mem_to_reg,
  output logic                    reg_dst,
  output logic                    reg_write,
  output logic                    alu_src,
  output logic                    branch,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    illegal_op,
  output logic [2:0]              state,
  output logic [CNT_WIDTH-1:0]    retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t                  st_q;
  state_t                  nxt;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic                    illegal_q;
  logic [CNT_WIDTH-1:0]    retired_q;

  logic [3:0] op_lo;
  logic [3:0] dec_lo;
  logic       is_lw;
  logic       is_sw;
  logic       is_bne;
  logic       dec_legal;
  logic       done;

  assign op_lo  = op_q[3:0];
  assign dec_lo = op_code[3:0];
  assign is_lw  = (op_lo == 4'h8);
  assign is_sw  = (op_lo == 4'hA);
  assign is_bne = (op_lo == 4'hE);

  // Any set bit above the 4-bit ISA field makes the opcode illegal.
  always_comb begin
    dec_legal = 1'b0;
    if ((op_code >> 4) == '0) begin
      case (dec_lo)
        4'h0, 4'h1, 4'h2, 4'h6,
        4'h7, 4'h8, 4'hA, 4'hE: dec_legal = 1'b1;
        default:                dec_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    done = 1'b0;
    nxt  = FETCH;
    unique case (st_q)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: nxt = dec_legal ? EXEC : FETCH;
      EXEC: begin
        if (is_bne) begin
          nxt  = FETCH;
          done = 1'b1;
        end else if (is_lw || is_sw) begin
          nxt = MEM;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        if (!mem_ready) begin
          nxt = MEM;
        end else if (is_lw) begin
          nxt = WB;
        end else begin
          nxt  = FETCH;
          done = 1'b1;
        end
      end
      WB: begin
        nxt  = FETCH;
        done = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      st_q      <= nxt;
      illegal_q <= (st_q == DECODE) && !dec_legal;
      if (st_q == DECODE) begin
        op_q <= op_code;
      end
      if (done) begin
        retired_q <= retired_q + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    alu_op     = '0;
    unique case (st_q)
      FETCH: begin
        mem_read = 1'b1;
        alu_op   = ALU_OP_WIDTH'(3'b010);
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      EXEC: begin
        unique case (1'b1)
          is_bne: begin
            alu_op   = ALU_OP_WIDTH'(3'b110);
            branch   = 1'b1;
            pc_write = !zero;
            pc_src   = !zero;
          end
          (is_lw || is_sw): begin
            alu_op  = ALU_OP_WIDTH'(3'b010);
            alu_src = 1'b1;
          end
          default: alu_op = ALU_OP_WIDTH'(op_lo[2:0]);
        endcase
      end
      MEM: begin
        i_or_d    = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = !is_lw;
        mem_to_reg = is_lw;
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign state      = st_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction cycle schedule model, directed
// cases then random instruction stream, second narrow-counter instance.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       pcs;
    logic       irw;
    logic       iod;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       rd;
    logic       rw;
    logic       as;
    logic       br;
    logic [2:0] alu;
    logic       ill;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  op_code;
  logic        zero;
  logic        mem_ready;

  logic        pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src, branch, illegal_op;
  logic [2:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        pc_write2, pc_src2, ir_write2, i_or_d2, mem_read2, mem_write2;
  logic        mem_to_reg2, reg_dst2, reg_write2, alu_src2, branch2;
  logic        illegal_op2;
  logic [3:0]  alu_op2;
  logic [2:0]  state2;
  logic [2:0]  retired2;

  int          tests = 0;
  int          fails = 0;
  int          ninstr = 0;
  logic [15:0] exp_ret = '0;
  logic        pend_ill = 1'b0;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src(alu_src), .branch(branch),
    .alu_op(alu_op), .illegal_op(illegal_op), .state(state),
    .retired(retired)
  );

  multicycle_control_unit #(
    .OPCODE_WIDTH(4), .ALU_OP_WIDTH(4), .CNT_WIDTH(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write2), .pc_src(pc_src2),
    .ir_write(ir_write2), .i_or_d(i_or_d2), .mem_read(mem_read2),
    .mem_write(mem_write2), .mem_to_reg(mem_to_reg2),
    .reg_dst(reg_dst2), .reg_write(reg_write2), .alu_src(alu_src2),
    .branch(branch2), .alu_op(alu_op2), .illegal_op(illegal_op2),
    .state(state2), .retired(retired2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t sample();
    return {state, pc_write, pc_src, ir_write, i_or_d, mem_read,
            mem_write, mem_to_reg, reg_dst, reg_write, alu_src, branch,
            alu_op, illegal_op};
  endfunction

  function automatic ctl_t e_fetch(input logic rdy, input logic ill);
    ctl_t e = '0;
    e.mr  = 1'b1;
    e.alu = 3'b010;
    e.irw = rdy;
    e.pcw = rdy;
    e.ill = ill;
    return e;
  endfunction

  // One clock: drive inputs at negedge, check 1ns later.
  task automatic cyc(input ctl_t e, input logic rdy, input logic z,
                     input logic [3:0] op);
    ctl_t o;
    @(negedge clk);
    mem_ready = rdy;
    zero      = z;
    op_code   = op;
    #1;
    o = sample();
    chk($sformatf("ctl#%0d", ninstr), 32'(o), 32'(e));
    chk($sformatf("retired#%0d", ninstr), 32'(retired), 32'(exp_ret));
    chk($sformatf("alu_ext#%0d", ninstr), 32'(alu_op2), 32'(e.alu));
    chk($sformatf("retired_w3#%0d", ninstr), 32'(retired2),
        32'(exp_ret[2:0]));
  endtask

  task automatic do_reset();
    ctl_t o;
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #1;
    exp_ret  = '0;
    pend_ill = 1'b0;
    o = sample();
    chk("reset_ctl", 32'(o), 32'(e_fetch(1'b0, 1'b0)));
    chk("reset_retired", 32'(retired), 32'(0));
    chk("reset_retired_w3", 32'(retired2), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Schedule of one instruction; ab >= 0 resets during MEM wait ab.
  task automatic run_instr(input logic [3:0] op, input int fw,
                           input int mw, input logic z, input int ab);
    ctl_t e;
    logic lw, sw, bne;
    ninstr++;
    lw  = (op == 4'h8);
    sw  = (op == 4'hA);
    bne = (op == 4'hE);
    for (int i = 0; i <= fw; i++) begin
      e = e_fetch(i == fw, pend_ill);
      cyc(e, i == fw, 1'($urandom), 4'($urandom));
      pend_ill = 1'b0;
    end
    e = '0;
    e.st = 3'd1;
    cyc(e, 1'($urandom), 1'($urandom), op);
    if (!(op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE})) begin
      pend_ill = 1'b1;
      return;
    end
    e = '0;
    e.st = 3'd2;
    if (bne) begin
      e.alu = 3'b110;
      e.br  = 1'b1;
      e.pcw = !z;
      e.pcs = !z;
    end else if (lw || sw) begin
      e.alu = 3'b010;
      e.as  = 1'b1;
    end else begin
      e.alu = op[2:0];
    end
    cyc(e, 1'($urandom), bne ? z : 1'($urandom), 4'($urandom));
    if (bne) begin
      exp_ret++;
      return;
    end
    if (lw || sw) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == ab) begin
          do_reset();
          return;
        end
        e = '0;
        e.st  = 3'd3;
        e.iod = 1'b1;
        e.mr  = lw;
        e.mw  = sw;
        cyc(e, i == mw, 1'($urandom), 4'($urandom));
      end
      if (sw) begin
        exp_ret++;
        return;
      end
    end
    e = '0;
    e.st  = 3'd4;
    e.rw  = 1'b1;
    e.rd  = !lw;
    e.m2r = lw;
    cyc(e, 1'($urandom), 1'($urandom), 4'($urandom));
    exp_ret++;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    op_code   = 4'h0;
    @(negedge clk);
    #1;
    chk("init_ctl", 32'(sample()), 32'(e_fetch(1'b0, 1'b0)));
    chk("init_retired", 32'(retired), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(4'h2, 0, 0, 1'b0, -1);
    run_instr(4'h8, 0, 3, 1'b0, -1);
    run_instr(4'hA, 1, 0, 1'b0, -1);
    run_instr(4'hE, 0, 0, 1'b0, -1);
    run_instr(4'hE, 0, 0, 1'b1, -1);
    run_instr(4'h3, 0, 0, 1'b0, -1);
    run_instr(4'h2, 0, 0, 1'b0, -1);
    run_instr(4'h6, 0, 0, 1'b0, -1);
    run_instr(4'h7, 0, 0, 1'b0, -1);
    run_instr(4'h8, 0, 3, 1'b0, 2);
    run_instr(4'h0, 0, 0, 1'b0, -1);
    run_instr(4'h1, 2, 0, 1'b0, -1);
    run_instr(4'h9, 0, 0, 1'b0, -1);
    run_instr(4'hA, 0, 2, 1'b0, -1);

    for (int k = 0; k < 80; k++) begin
      run_instr(4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
